// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit CPU core: ROM fetch, decoder handshake, write strobes, PC.
// Optional retire counter output enabled by defining SEQ_RETIRE_CNT_EN.
module cpu_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  output logic [7:0]      opcode_q,
  output logic [7:0]      operand_q,
  input  logic            alu_operation,
  input  logic            alu_multibyte_result,
  input  logic            jump_operation,
  input  logic            jump_condition,
  input  logic            mov_operation,
  input  logic            destination_w,
  input  logic            destination_flags,
  input  logic            destination_memory,
  input  logic            destination_registers,
  input  logic            destination_ports,
  input  logic            ram_operand,
  input  logic            duplicate_w,
  output logic            ram_rd,
  output logic            w_we,
  output logic            flags_we,
  output logic            mem_we,
  output logic            reg_we,
  output logic            port_we,
  output logic            mb_hi,
  output logic [PC_W-1:0] pc,
  output logic            busy
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]     retire_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH_OP  = 3'd0,
    ST_FETCH_ARG = 3'd1,
    ST_DECODE    = 3'd2,
    ST_MEM_RD    = 3'd3,
    ST_EXEC      = 3'd4,
    ST_EXEC_HI   = 3'd5,
    ST_DISPATCH  = 3'd6
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t next_s;
  state_t cur_s;
  logic   fetch_s;
  logic   taken_s;
  logic   unused_inputs;

  // alu_operation only selects the datapath function; duplicate_w is realised by the decoder
  // asserting destination_w and destination_memory together.
  assign unused_inputs = alu_operation ^ duplicate_w;

  assign rom_addr = pc;
  assign fetch_s  = rom_req & rom_ack;
  assign taken_s  = (cur_s == ST_EXEC) & jump_operation & jump_condition;

  // The decoder output is only valid the cycle after DECODE, so the MEM_RD/EXEC choice is made here.
  always_comb begin
    if (state_r == ST_DISPATCH) begin
      cur_s = ram_operand ? ST_MEM_RD : ST_EXEC;
    end else begin
      cur_s = state_r;
    end
  end

  // State register, program counter and instruction byte latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_FETCH_OP;
      pc        <= PC_W'(RESET_PC);
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_r <= next_s;
      if (fetch_s) begin
        pc <= pc + PC_ONE;
      end else if (taken_s) begin
        pc <= PC_W'(operand_q);
      end
      if (fetch_s && (cur_s == ST_FETCH_OP)) begin
        opcode_q <= rom_data;
      end
      if (fetch_s && (cur_s == ST_FETCH_ARG)) begin
        operand_q <= rom_data;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    next_s = cur_s;
    case (cur_s)
      ST_FETCH_OP: begin
        if (fetch_s) begin
          next_s = rom_data[7] ? ST_FETCH_ARG : ST_DECODE;
        end else begin
          next_s = ST_FETCH_OP;
        end
      end
      ST_FETCH_ARG: begin
        if (fetch_s) begin
          next_s = ST_DECODE;
        end else begin
          next_s = ST_FETCH_ARG;
        end
      end
      ST_DECODE:  next_s = ST_DISPATCH;
      ST_MEM_RD:  next_s = ST_EXEC;
      ST_EXEC: begin
        if (alu_multibyte_result) begin
          next_s = ST_EXEC_HI;
        end else begin
          next_s = ST_FETCH_OP;
        end
      end
      ST_EXEC_HI: next_s = ST_FETCH_OP;
      default:    next_s = ST_FETCH_OP;
    endcase
  end

  // Handshake and write strobes; a taken jump suppresses every strobe.
  always_comb begin
    rom_req  = 1'b0;
    ram_rd   = 1'b0;
    w_we     = 1'b0;
    flags_we = 1'b0;
    mem_we   = 1'b0;
    reg_we   = 1'b0;
    port_we  = 1'b0;
    mb_hi    = 1'b0;
    busy     = 1'b1;
    case (cur_s)
      ST_FETCH_OP: begin
        if (hold) begin
          busy = 1'b0;
        end else begin
          rom_req = rst_n;
        end
      end
      ST_FETCH_ARG: rom_req = rst_n;
      ST_MEM_RD:    ram_rd = 1'b1;
      ST_EXEC: begin
        if (!taken_s) begin
          w_we     = destination_w;
          flags_we = destination_flags;
          mem_we   = destination_memory & ~alu_multibyte_result;
          reg_we   = destination_registers & mov_operation;
          port_we  = destination_ports & mov_operation;
        end else begin
          w_we = 1'b0;
        end
      end
      ST_EXEC_HI: begin
        mem_we = 1'b1;
        mb_hi  = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

`ifdef SEQ_RETIRE_CNT_EN
  // Counts instructions returning to FETCH_OP from an execute phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 16'h0000;
    end else if ((next_s == ST_FETCH_OP) && ((cur_s == ST_EXEC) || (cur_s == ST_EXEC_HI))) begin
      retire_cnt <= retire_cnt + 16'h0001;
    end else begin
      retire_cnt <= retire_cnt;
    end
  end
`endif

endmodule
